// File: rtl/mem_16x32.sv
// Single-port synchronous memory with registered, valid-qualified read data.
// Optional MEM_RESET_CLEAR_EN: the synchronous reset also zeroes the array.
module mem_16x32 #(
  parameter int Data_Width    = 32,
  parameter int Address_Width = 4,
  parameter int Locations_Num = 16
) (
  input  logic                     CLK,
  input  logic                     Rst_n,
  input  logic                     Wr_En,
  input  logic                     Rd_En,
  input  logic [Data_Width-1:0]    Data_in,
  input  logic [Address_Width-1:0] Address,
  output logic [Data_Width-1:0]    Data_out,
  output logic                     Valid_out
);

  localparam int IDX_W = (Locations_Num > 1) ? $clog2(Locations_Num) : 1;
  localparam logic [Address_Width:0] LOC_LIMIT = (Address_Width+1)'(Locations_Num);

  logic [Data_Width-1:0] mem [Locations_Num];
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  // Extra top bit keeps the compare valid when Locations_Num == 2**Address_Width.
  assign in_range = {1'b0, Address} < LOC_LIMIT;
  assign idx      = Address[IDX_W-1:0];

  always_ff @(posedge CLK) begin
    if (!Rst_n) begin
      Data_out  <= '0;
      Valid_out <= 1'b0;
`ifdef MEM_RESET_CLEAR_EN
      for (int i = 0; i < Locations_Num; i++) mem[i] <= '0;
`endif
    end else begin
      Valid_out <= Rd_En;
      // Non-blocking read of mem gives read-before-write on a same-cycle write.
      if (Rd_En) Data_out <= in_range ? mem[idx] : '0;
      if (Wr_En && in_range) mem[idx] <= Data_in;
    end
  end

endmodule

// File: tb/tb_mem_16x32.sv
// Directed self-checking bench for mem_16x32 (16 words, 5-bit address to reach out-of-range).
module tb_mem_16x32;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LN = 16;

  logic          CLK = 1'b0;
  logic          Rst_n;
  logic          Wr_En, Rd_En;
  logic [DW-1:0] Data_in;
  logic [AW-1:0] Address;
  logic [DW-1:0] Data_out;
  logic          Valid_out;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [LN];

  always #5 CLK = ~CLK;

  mem_16x32 #(.Data_Width(DW), .Address_Width(AW), .Locations_Num(LN)) dut (
    .CLK(CLK), .Rst_n(Rst_n), .Wr_En(Wr_En), .Rd_En(Rd_En), .Data_in(Data_in),
    .Address(Address), .Data_out(Data_out), .Valid_out(Valid_out)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cmd(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    Wr_En = wr; Rd_En = rd; Address = a; Data_in = d;
  endtask

  initial begin
    Rst_n = 1'b0;
    cmd(1'b0, 1'b1, 5'd3, 32'h0);
    for (int i = 0; i < LN; i++) model[i] = 'x;
    step();
    chk("rst_data", Data_out, 32'h0);
    chk("rst_valid", {31'b0, Valid_out}, 32'h0);
    Rst_n = 1'b1;

`ifdef MEM_RESET_CLEAR_EN
    for (int i = 0; i < LN; i++) model[i] = '0;
    cmd(1'b0, 1'b1, 5'd3, 32'h0);
    step();
    chk("clr_data", Data_out, 32'h0);
    chk("clr_valid", {31'b0, Valid_out}, 32'h1);
`endif

    // Write then read
    cmd(1'b1, 1'b0, 5'd5, 32'hDEADBEEF); step();
    chk("wr_only_valid", {31'b0, Valid_out}, 32'h0);
    cmd(1'b0, 1'b1, 5'd5, 32'h0); step();
    chk("rd5_data", Data_out, 32'hDEADBEEF);
    chk("rd5_valid", {31'b0, Valid_out}, 32'h1);
    cmd(1'b0, 1'b0, 5'd0, 32'h0); step();
    chk("idle_valid", {31'b0, Valid_out}, 32'h0);
    chk("idle_hold", Data_out, 32'hDEADBEEF);

    // Full sweep
    for (int a = 0; a < LN; a++) begin
      model[a] = DW'(a) * 32'h11111111;
      cmd(1'b1, 1'b0, AW'(a), model[a]); step();
    end
    for (int a = 0; a < LN; a++) begin
      cmd(1'b0, 1'b1, AW'(a), 32'h0); step();
      chk($sformatf("sweep_data[%0d]", a), Data_out, model[a]);
      chk($sformatf("sweep_valid[%0d]", a), {31'b0, Valid_out}, 32'h1);
    end
    cmd(1'b0, 1'b0, 5'd0, 32'h0); step();
    chk("sweep_end_valid", {31'b0, Valid_out}, 32'h0);

    // Read-before-write
    cmd(1'b1, 1'b0, 5'd2, 32'hA5A5A5A5); step();
    model[2] = 32'hA5A5A5A5;
    cmd(1'b1, 1'b1, 5'd2, 32'h12345678); step();
    chk("rbw_old", Data_out, 32'hA5A5A5A5);
    chk("rbw_valid", {31'b0, Valid_out}, 32'h1);
    model[2] = 32'h12345678;
    cmd(1'b0, 1'b1, 5'd2, 32'h0); step();
    chk("rbw_new", Data_out, 32'h12345678);

    // Out-of-range
    cmd(1'b1, 1'b0, 5'd20, 32'hFFFFFFFF); step();
    cmd(1'b0, 1'b1, 5'd20, 32'h0); step();
    chk("oor_data", Data_out, 32'h0);
    chk("oor_valid", {31'b0, Valid_out}, 32'h1);
    cmd(1'b0, 1'b1, 5'd31, 32'h0); step();
    chk("oor31_data", Data_out, 32'h0);
    for (int a = 0; a < LN; a++) begin
      cmd(1'b0, 1'b1, AW'(a), 32'h0); step();
      chk($sformatf("oor_intact[%0d]", a), Data_out, model[a]);
    end

    // Reset mid-stream: read and write in flight are discarded
    cmd(1'b0, 1'b1, 5'd5, 32'h0); step();
    chk("pre_rst_data", Data_out, model[5]);
    Rst_n = 1'b0;
    cmd(1'b1, 1'b1, 5'd7, 32'hCAFEF00D); step();
    chk("mid_rst_data", Data_out, 32'h0);
    chk("mid_rst_valid", {31'b0, Valid_out}, 32'h0);
`ifdef MEM_RESET_CLEAR_EN
    for (int i = 0; i < LN; i++) model[i] = '0;
`endif
    Rst_n = 1'b1;
    cmd(1'b0, 1'b1, 5'd7, 32'h0); step();
    chk("post_rst_data", Data_out, model[7]);
    chk("post_rst_valid", {31'b0, Valid_out}, 32'h1);
    cmd(1'b0, 1'b0, 5'd0, 32'h0); step();
    chk("post_rst_idle", {31'b0, Valid_out}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_16x32.md
# mem_16x32

Single-port, synchronous read/write memory: 16 words of 32 bits by default, with every dimension parameterised. It is the storage element behind the `memory_if` interface in the memory verification environment. The block accepts one write or read command per clock. Read data is registered and returned one cycle later, qualified by a valid strobe.

## Interface
Parameters:
- `Data_Width`, default 32: word width in bits.
- `Address_Width`, default 4: address bus width.
- `Locations_Num`, default 16: number of words. Must satisfy `Locations_Num <= 2**Address_Width`.

Ports:
- `CLK`, input, 1: single clock. All logic is on the rising edge.
- `Rst_n`, input, 1: reset, synchronous and active-low.
- `Wr_En`, input, 1: write enable.
- `Rd_En`, input, 1: read enable.
- `Data_in`, input, `Data_Width`: write data.
- `Address`, input, `Address_Width`: word address for both read and write.
- `Data_out`, output, `Data_Width`: registered read data.
- `Valid_out`, output, 1: high for exactly one cycle when `Data_out` carries new read data.

## Operation
- Storage is an array of `Locations_Num` words of `Data_Width` bits.
- **Reset.** Sampled at a rising `CLK` edge with `Rst_n`=0:
  - `Data_out` ← 0 and `Valid_out` ← 0.
  - Any command in that cycle is ignored.
  - Array clearing is controlled by the configuration macro below.
- **Write** (`Wr_En`=1, `Address` < `Locations_Num`): `mem[Address]` ← `Data_in` at the clock edge.
- **Read** (`Rd_En`=1):
  - `Data_out` ← `mem[Address]` and `Valid_out` ← 1 at the clock edge.
- **Simultaneous read and write** (`Wr_En`=1, `Rd_En`=1):
  - Both operations are performed.
  - The read returns the pre-write contents (read-before-write).
  - The write lands in the array as normal.
- **Out-of-range address** (`Address` >= `Locations_Num`):
  - A write is silently dropped.
  - A read returns `Data_out`=0 with `Valid_out`=1.
- **Idle** (`Rd_En`=0): `Valid_out` ← 0 and `Data_out` holds its last value.
- There is no back-pressure. A new command is accepted every cycle.

## Timing
- Write latency is 1 cycle. Data written at edge N is readable by a read issued at edge N+1.
- Read latency is 1 cycle. A read sampled at edge N produces `Data_out`/`Valid_out` valid after edge N, for the cycle up to edge N+1.
- Back-to-back reads produce `Valid_out` continuously high, with `Data_out` updating each cycle.
- Reset asserted mid-stream:
  - The next edge forces both outputs to 0.
  - The command in flight is discarded.
  - Operation resumes at the first edge with `Rst_n`=1.
- Outputs are driven directly from flops. There is no combinational path from inputs to outputs.

## Configuration
- Macro `MEM_RESET_CLEAR_EN`.
- **Defined:** the synchronous reset also clears every array location to 0. A read after reset, with no intervening write, returns 0.
- **Undefined:** reset affects only `Data_out` and `Valid_out`. Array contents are preserved across reset; after power-up they are unspecified (X in simulation).

## Test plan
- Reset check: hold `Rst_n`=0 for one edge, then release → `Data_out`=0 and `Valid_out`=0. With `MEM_RESET_CLEAR_EN` defined, reading address 3 → `Data_out`=0, `Valid_out`=1.
- Write then read:
  - Write 0xDEADBEEF to address 5, then read address 5 on the next cycle.
  - → One cycle after the read, `Data_out`=0xDEADBEEF and `Valid_out`=1.
  - → The following idle cycle has `Valid_out`=0 with `Data_out` unchanged.
- Full sweep: write `addr*0x11111111` to every address 0..`Locations_Num`-1, then read them back-to-back → each word matches, and `Valid_out` stays high for `Locations_Num` consecutive cycles.
- Read-before-write:
  - Address 2 holds 0xA5A5A5A5. In one cycle, assert `Wr_En`=1 and `Rd_En`=1 with `Data_in`=0x12345678.
  - → `Data_out`=0xA5A5A5A5.
  - → A subsequent read of address 2 returns 0x12345678.
- Out-of-range (`Locations_Num`=16, `Address_Width`=5): write 0xFFFFFFFF to address 20, then read address 20 → `Data_out`=0 and `Valid_out`=1. No in-range word is modified.
- Reset mid-stream: issue a read with `Rst_n`=0 in the same cycle → next cycle `Valid_out`=0 and `Data_out`=0. A read after release behaves normally.
